// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and PC select codes for the fetch sequencer
package pc_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STEP, S_JUMP, S_STOP, S_ERROR} state_e;
  localparam logic [1:0] SEL_RST  = 2'b00;
  localparam logic [1:0] SEL_HOLD = 2'b01;
  localparam logic [1:0] SEL_INC  = 2'b10;
  localparam logic [1:0] SEL_JUMP = 2'b11;
endpackage

// File: rtl/pc_seq_timer.sv
// pc_seq_timer: clearable/freezable wait counter, expired at MAX_WAIT-1
module pc_seq_timer #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(MAX_WAIT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = cnt_q == CW'(MAX_WAIT - 1);
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch sequencer driving PC select, jump target and memory request
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         stall_i,
  input  logic         halt_i,
  input  logic         br_valid_i,
  input  logic [W-1:0] br_target_i,
  output logic         br_ready_o,
  input  logic         mem_ack_i,
  output logic         mem_req_o,
  output logic [1:0]   sel_o,
  output logic [W-1:0] pc_tgt_o,
  output logic         busy_o,
  output logic         halted_o,
  output logic         err_o
);
  state_e state_q, state_d;
  logic br_pend_q, br_pend_d, halt_pend_q, halt_pend_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic active, br_take, halt_now, fetch_go, expired;
  assign active   = state_q inside {S_FETCH, S_STEP, S_JUMP};
  assign br_take  = br_valid_i & br_ready_o;
  assign halt_now = halt_pend_q | halt_i;
  assign fetch_go = state_q == S_FETCH & ~stall_i;
  pc_seq_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != S_FETCH | (fetch_go & mem_ack_i)),
    .en_i     (fetch_go & ~mem_ack_i),
    .expired_o(expired)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      br_pend_q   <= 1'b0;
      halt_pend_q <= 1'b0;
      tgt_q       <= '0;
    end else begin
      state_q     <= state_d;
      br_pend_q   <= br_pend_d;
      halt_pend_q <= halt_pend_d;
      tgt_q       <= tgt_d;
    end
  end
  // a branch latched in the same cycle as the ack is taken immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_STOP: state_d = start_i ? S_FETCH : state_q;
      S_FETCH: if (fetch_go)
        state_d = mem_ack_i ? ((br_pend_q | br_take) ? S_JUMP : S_STEP) : (expired ? S_ERROR : S_FETCH);
      S_STEP, S_JUMP: state_d = halt_now ? S_STOP : S_FETCH;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    br_pend_d   = state_q == S_JUMP ? 1'b0 : br_pend_q | br_take;
    tgt_d       = br_take ? br_target_i : tgt_q;
    halt_pend_d = state_d == S_STOP ? 1'b0 : halt_pend_q | (active & halt_i);
  end
  always_comb begin
    br_ready_o = active & ~br_pend_q;
    mem_req_o  = state_q == S_FETCH;
    sel_o      = state_q == S_IDLE ? SEL_RST : state_q == S_STEP ? SEL_INC :
                 state_q == S_JUMP ? SEL_JUMP : SEL_HOLD;
    pc_tgt_o   = tgt_q;
    busy_o     = active;
    halted_o   = state_q == S_STOP;
    err_o      = state_q == S_ERROR;
  end
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed self-checking bench for the fetch sequencer
module tb_pc_seq_ctrl;
  logic clk = 1'b0;
  logic rst, start_i, stall_i, halt_i, br_valid_i, mem_ack_i;
  logic [7:0] br_target_i, pc_tgt_o;
  logic br_ready_o, mem_req_o, busy_o, halted_o, err_o;
  logic [1:0] sel_o;
  logic [7:0] pc_m;
  int n_assert = 0;
  int n_fail = 0;

  pc_seq_ctrl #(.W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stall_i(stall_i), .halt_i(halt_i),
    .br_valid_i(br_valid_i), .br_target_i(br_target_i), .br_ready_o(br_ready_o),
    .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o), .sel_o(sel_o), .pc_tgt_o(pc_tgt_o),
    .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // behavioural PC register fed by the sequencer's select and target
  always @(posedge clk)
    case (sel_o)
      2'b00: pc_m <= 8'h00;
      2'b10: pc_m <= pc_m + 8'h04;
      2'b11: pc_m <= pc_tgt_o;
      default: pc_m <= pc_m;
    endcase

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // status bundle {sel, mem_req, busy, halted, err, br_ready}
  function automatic logic [6:0] st();
    return {sel_o, mem_req_o, busy_o, halted_o, err_o, br_ready_o};
  endfunction

  initial begin
    rst = 1'b0; start_i = 1'b0; stall_i = 1'b0; halt_i = 1'b0;
    br_valid_i = 1'b0; br_target_i = 8'h00; mem_ack_i = 1'b0;
    step(); step();
    chk("reset_status", st(), 7'b00_0_0_0_0_0);
    chk("reset_tgt", pc_tgt_o, 8'h00);
    chk("reset_pc", pc_m, 8'h00);
    rst = 1'b1;
    step();
    chk("idle_hold", st(), 7'b00_0_0_0_0_0);
    // sequential fetch: 01,10 pattern, three instructions
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("fetch_entry", st(), 7'b01_1_1_0_0_1);
    for (int i = 0; i < 3; i++) begin
      mem_ack_i = 1'b1; step();
      chk("seq_step_sel", sel_o, 2'b10);
      mem_ack_i = 1'b0; step();
      chk("seq_fetch_sel", sel_o, 2'b01);
    end
    chk("seq_pc_0c", pc_m, 8'h0C);
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("start_ignored", st(), 7'b01_1_1_0_0_1);
    // branch captured one cycle before the ack
    br_valid_i = 1'b1; br_target_i = 8'h40; step(); br_valid_i = 1'b0; br_target_i = 8'h00;
    chk("br_captured_ready", br_ready_o, 1'b0);
    chk("br_captured_tgt", pc_tgt_o, 8'h40);
    chk("br_wait_fetch", sel_o, 2'b01);
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    chk("jump_status", st(), 7'b11_0_1_0_0_0);
    chk("jump_tgt", pc_tgt_o, 8'h40);
    step();
    chk("after_jump", st(), 7'b01_1_1_0_0_1);
    chk("pc_at_40", pc_m, 8'h40);
    // halt + branch + ack in one FETCH cycle: JUMP then STOP
    halt_i = 1'b1; br_valid_i = 1'b1; br_target_i = 8'h80; mem_ack_i = 1'b1;
    step();
    halt_i = 1'b0; br_valid_i = 1'b0; br_target_i = 8'h00; mem_ack_i = 1'b0;
    chk("hb_jump", st(), 7'b11_0_1_0_0_0);
    chk("hb_tgt", pc_tgt_o, 8'h80);
    step();
    chk("hb_stop", st(), 7'b01_0_0_1_0_0);
    chk("pc_at_80", pc_m, 8'h80);
    step();
    chk("stop_hold", st(), 7'b01_0_0_1_0_0);
    chk("tgt_kept", pc_tgt_o, 8'h80);
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("stop_resume", st(), 7'b01_1_1_0_0_1);
    // timeout: three waits stay in FETCH, fourth goes to ERROR
    step(); step(); step();
    chk("wait3_fetch", st(), 7'b01_1_1_0_0_1);
    step();
    chk("timeout_err", st(), 7'b01_0_0_0_1_0);
    start_i = 1'b1; mem_ack_i = 1'b1; step(); step(); start_i = 1'b0; mem_ack_i = 1'b0;
    chk("err_sticky", st(), 7'b01_0_0_0_1_0);
    rst = 1'b0; step(); rst = 1'b1;
    chk("err_cleared", st(), 7'b00_0_0_0_0_0);
    // stall cycles inside the wait window do not count
    start_i = 1'b1; step(); start_i = 1'b0;
    step(); step();
    stall_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ack_i = (i == 4);
      step();
      chk("stall_no_err", {err_o, mem_req_o, sel_o}, 4'b0_1_01);
    end
    stall_i = 1'b0; mem_ack_i = 1'b0;
    step();
    chk("post_stall_fetch", st(), 7'b01_1_1_0_0_1);
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    chk("post_stall_step", sel_o, 2'b10);
    step();
    // reset during JUMP with halt pending
    br_valid_i = 1'b1; br_target_i = 8'h20; halt_i = 1'b1; mem_ack_i = 1'b1;
    step();
    br_valid_i = 1'b0; br_target_i = 8'h00; halt_i = 1'b0; mem_ack_i = 1'b0;
    chk("rj_jump", sel_o, 2'b11);
    rst = 1'b0; step(); rst = 1'b1;
    chk("rj_idle", st(), 7'b00_0_0_0_0_0);
    chk("rj_tgt", pc_tgt_o, 8'h00);
    start_i = 1'b1; step(); start_i = 1'b0;
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    chk("rj_no_stale_br", sel_o, 2'b10);
    step();
    chk("rj_no_stale_halt", st(), 7'b01_1_1_0_0_1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
